// File: rtl/mem_access_seq_pkg.sv
// Shared types and constants for the memory access sequencer.
package mem_access_seq_pkg;

    // Default bus widths for MAR (address) and MBR (data)
    localparam int AW_DEF = 8;
    localparam int DW_DEF = 8;

    // rnw encoding on the RAM side
    localparam logic RNW_READ = 1'b1;

    // Transaction state encoding
    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_SETUP  = 3'd1,
        ST_ACCESS = 3'd2,
        ST_DONE   = 3'd3,
        ST_ERROR  = 3'd4
    } state_t;

endpackage

// File: rtl/mem_access_seq_wait_timer.sv
// MFC wait timer: counts ACCESS cycles and flags the last allowed one.
module wait_timer #(
    parameter int TW      = 4,
    parameter int TIMEOUT = 15
) (
    input  logic CLK,
    input  logic RST_N,
    input  logic clr,
    input  logic en,
    output logic hit
);

    localparam logic [TW-1:0] LAST = TW'(TIMEOUT - 1);

    logic [TW-1:0] cnt;

    // Counter: clear has priority; the owner never enables it past LAST
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (en) begin
            cnt <= cnt + 1'b1;
        end
    end

    assign hit = (cnt == LAST);

endmodule

// File: rtl/mem_access_seq.sv
// Initiator side of the CPU<->RAM handshake: one request at a time,
// SETUP -> ACCESS (wait for MFC, bounded) -> DONE or ERROR pulse.
module mem_access_seq
    import mem_access_seq_pkg::*;
#(
    parameter int AW      = AW_DEF,
    parameter int DW      = DW_DEF,
    parameter int TIMEOUT = 15,
    parameter int TW      = 4
) (
    input  logic          CLK,
    input  logic          RST_N,
    input  logic          req,
    input  logic          req_rnw,
    input  logic [AW-1:0] req_addr,
    input  logic [DW-1:0] req_wdata,
    output logic          busy,
    output logic          done,
    output logic          err,
    output logic [DW-1:0] rdata,
    output logic [AW-1:0] mem_addr,
    output logic          mem_enable,
    output logic          mem_rnw,
    output logic [DW-1:0] mem_wdata,
    output logic          mem_wdata_oe,
    input  logic [DW-1:0] mem_rdata,
    input  logic          MFC
);

    state_t        state, state_nx;
    logic          rnw_q;
    logic [AW-1:0] addr_q;
    logic [DW-1:0] wdata_q;
    logic          accept;
    logic          tmr_clr, tmr_en, tmr_hit;
    logic          active;
    logic          is_read;

    assign accept  = (state == ST_IDLE) && req;
    assign active  = (state == ST_SETUP) || (state == ST_ACCESS);
    assign is_read = (rnw_q == RNW_READ);

    wait_timer #(
        .TW      (TW),
        .TIMEOUT (TIMEOUT)
    ) u_wait_timer (
        .CLK   (CLK),
        .RST_N (RST_N),
        .clr   (tmr_clr),
        .en    (tmr_en),
        .hit   (tmr_hit)
    );

    // State register
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // Direction latch: controls output gating, so it is reset
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            rnw_q <= 1'b0;
        end else if (accept) begin
            rnw_q <= req_rnw;
        end
    end

    // Address/data latches: only visible through state gating, no reset needed
    always_ff @(posedge CLK) begin
        if (accept) begin
            addr_q  <= req_addr;
            wdata_q <= req_wdata;
        end
    end

    // Read data: updated only on the edge where a read sees MFC
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            rdata <= '0;
        end else if ((state == ST_ACCESS) && MFC && is_read) begin
            rdata <= mem_rdata;
        end
    end

    // Next-state and timer control; MFC on the last count beats the timeout
    always_comb begin
        state_nx = state;
        tmr_clr  = 1'b0;
        tmr_en   = 1'b0;
        case (state)
            ST_IDLE: begin
                if (req) state_nx = ST_SETUP;
            end
            ST_SETUP: begin
                tmr_clr  = 1'b1;
                state_nx = ST_ACCESS;
            end
            ST_ACCESS: begin
                if (MFC) begin
                    state_nx = ST_DONE;
                end else if (tmr_hit) begin
                    state_nx = ST_ERROR;
                end else begin
                    tmr_en = 1'b1;
                end
            end
            ST_DONE:  state_nx = ST_IDLE;
            ST_ERROR: state_nx = ST_IDLE;
            default:  state_nx = ST_IDLE;
        endcase
    end

    // Outputs decode straight from state so reset drops them immediately
    always_comb begin
        busy         = active;
        done         = (state == ST_DONE);
        err          = (state == ST_ERROR);
        mem_enable   = (state == ST_ACCESS);
        mem_addr     = active ? addr_q : '0;
        mem_rnw      = active && is_read;
        mem_wdata_oe = active && !is_read;
        mem_wdata    = (active && !is_read) ? wdata_q : '0;
    end

endmodule

// File: tb/tb_mem_access_seq.sv
// Scoreboard bench for mem_access_seq: stimulus pushes expected completions,
// a monitor pops and compares on every done/err pulse.
module tb_mem_access_seq;

    logic       CLK = 1'b0;
    logic       RST_N = 1'b0;
    logic       req = 1'b0;
    logic       req_rnw = 1'b0;
    logic [7:0] req_addr = '0;
    logic [7:0] req_wdata = '0;
    logic       busy, done, err;
    logic [7:0] rdata;
    logic [7:0] mem_addr;
    logic       mem_enable, mem_rnw;
    logic [7:0] mem_wdata;
    logic       mem_wdata_oe;
    logic [7:0] mem_rdata = '0;
    logic       MFC = 1'b0;

    typedef struct {
        logic       is_err;
        logic [7:0] rdata;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;
    logic [7:0] exp_rdata = 8'h00;

    mem_access_seq #(.AW(8), .DW(8), .TIMEOUT(15), .TW(4)) dut (
        .CLK          (CLK),
        .RST_N        (RST_N),
        .req          (req),
        .req_rnw      (req_rnw),
        .req_addr     (req_addr),
        .req_wdata    (req_wdata),
        .busy         (busy),
        .done         (done),
        .err          (err),
        .rdata        (rdata),
        .mem_addr     (mem_addr),
        .mem_enable   (mem_enable),
        .mem_rnw      (mem_rnw),
        .mem_wdata    (mem_wdata),
        .mem_wdata_oe (mem_wdata_oe),
        .mem_rdata    (mem_rdata),
        .MFC          (MFC)
    );

    always #5 CLK = ~CLK;

    function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endfunction

    // Monitor: every completion pulse must match the oldest expectation
    always @(negedge CLK) begin
        if (done || err) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_completion", {30'd0, done, err}, 32'd0);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                chk("completion_is_err", {31'd0, err}, {31'd0, e.is_err});
                chk("completion_done", {31'd0, done}, {31'd0, ~e.is_err});
                chk("completion_rdata", {24'd0, rdata}, {24'd0, e.rdata});
            end
        end
    end

    // One request; mfc_at = ACCESS cycle (1-based) in which MFC is raised, 0 = never
    task automatic run_txn(input logic rnw, input logic [7:0] addr, input logic [7:0] wdata,
                           input logic [7:0] rd, input int mfc_at);
        int   exp_en, lat, en_cnt, oe_cnt;
        logic bad_bus, bad_busy;
        exp_t e;
        if (mfc_at >= 1 && mfc_at <= 15) begin
            exp_en = mfc_at;
            if (rnw) exp_rdata = rd;
            e.is_err = 1'b0;
        end else begin
            exp_en = 15;
            e.is_err = 1'b1;
        end
        e.rdata = exp_rdata;
        exp_q.push_back(e);
        lat = 0; en_cnt = 0; oe_cnt = 0; bad_bus = 1'b0; bad_busy = 1'b0;

        @(posedge CLK); #1;
        req = 1'b1; req_rnw = rnw; req_addr = addr; req_wdata = wdata; mem_rdata = rd;
        @(posedge CLK); #1;
        req = 1'b0; req_rnw = ~rnw; req_addr = ~addr; req_wdata = ~wdata;
        for (int cyc = 1; cyc <= 40; cyc++) begin
            @(negedge CLK);
            if (done || err) begin
                lat = cyc;
                break;
            end
            if (!busy) bad_busy = 1'b1;
            if (mem_enable) en_cnt++;
            if (mem_wdata_oe) oe_cnt++;
            if (mem_addr !== addr || mem_rnw !== rnw) bad_bus = 1'b1;
            if (!rnw && mem_wdata !== wdata) bad_bus = 1'b1;
            MFC = mem_enable && (en_cnt == mfc_at);
        end
        MFC = 1'b0;
        chk("latency", lat, exp_en + 2);
        chk("enable_cycles", en_cnt, exp_en);
        chk("oe_cycles", oe_cnt, rnw ? 0 : exp_en + 1);
        chk("bus_fields_stable", {31'd0, bad_bus}, 32'd0);
        chk("busy_during_txn", {31'd0, bad_busy}, 32'd0);
        chk("end_cycle_idle_bus", {busy, mem_enable, mem_wdata_oe, mem_rnw, 8'd0, mem_addr}, 32'd0);
        @(negedge CLK);
        chk("pulse_width", {30'd0, done, err}, 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset state
        #12;
        chk("reset_outputs", {busy, done, err, mem_enable, mem_rnw, mem_wdata_oe, 26'd0}, 32'd0);
        chk("reset_bus", {8'd0, rdata, mem_addr, mem_wdata}, 32'd0);
        #10 RST_N = 1'b1;

        // 1: read, immediate MFC
        run_txn(1'b1, 8'h3C, 8'h00, 8'hA5, 1);
        // 2: write, MFC in 4th ACCESS cycle; rdata stays A5
        run_txn(1'b0, 8'h10, 8'h7E, 8'h11, 4);
        // 3: read, no MFC -> timeout; rdata stays A5
        run_txn(1'b1, 8'hC0, 8'h00, 8'h22, 0);
        // 4: MFC on the final ACCESS cycle wins
        run_txn(1'b1, 8'h55, 8'h00, 8'h5C, 15);

        // 4b: MFC in IDLE has no effect
        MFC = 1'b1;
        repeat (3) begin
            @(negedge CLK);
            chk("idle_mfc_ignored", {29'd0, busy, done, mem_enable}, 32'd0);
        end
        MFC = 1'b0;

        // 5: req held high for two back-to-back reads, immediate MFC
        begin
            exp_t e;
            e.is_err = 1'b0; e.rdata = 8'hC3; exp_q.push_back(e);
            e.rdata = 8'h5A; exp_q.push_back(e);
            exp_rdata = 8'h5A;
            @(posedge CLK); #1;
            req = 1'b1; req_rnw = 1'b1; req_addr = 8'h20; mem_rdata = 8'hC3; MFC = 1'b1;
            @(posedge CLK); #1;
            req_addr = 8'h55;
            @(negedge CLK); chk("b2b_setup_addr", mem_addr, 8'h20);
            @(negedge CLK); chk("b2b_access_addr", {mem_enable, mem_addr}, {1'b1, 8'h20});
            @(negedge CLK); chk("b2b_first_done", done, 1'b1);
            mem_rdata = 8'h5A;
            @(negedge CLK); chk("b2b_idle_gap", {busy, done}, 2'b00);
            @(negedge CLK); chk("b2b_second_setup", {busy, mem_addr}, {1'b1, 8'h55});
            @(negedge CLK); chk("b2b_second_access", mem_enable, 1'b1);
            @(negedge CLK); chk("b2b_second_done", done, 1'b1);
            req = 1'b0; MFC = 1'b0;
            @(negedge CLK); chk("b2b_no_third", busy, 1'b0);
        end

        // 6: reset during ACCESS of a write
        @(posedge CLK); #1;
        req = 1'b1; req_rnw = 1'b0; req_addr = 8'h44; req_wdata = 8'h66;
        @(posedge CLK); #1;
        req = 1'b0;
        @(negedge CLK);
        @(negedge CLK);
        chk("pre_reset_access", {mem_enable, mem_wdata_oe}, 2'b11);
        #2 RST_N = 1'b0;
        #1 chk("async_reset_drop", {busy, mem_enable, mem_wdata_oe, mem_addr}, 11'd0);
        repeat (2) @(posedge CLK);
        #2 RST_N = 1'b1;
        exp_rdata = 8'h00;
        chk("reset_clears_rdata", rdata, 8'h00);
        run_txn(1'b1, 8'h3C, 8'h00, 8'h81, 2);

        repeat (3) @(negedge CLK);
        chk("scoreboard_drained", exp_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
